// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle for the iterative divider.
interface seq_divider_if #(
  parameter int BITS = 8
);
  logic            start;
  logic [BITS-1:0] dividend;
  logic [BITS-1:0] divisor;
  logic            busy;
  logic            done;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;
  logic            div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Trial subtraction is one's-complement addition; its carry-out is the no-borrow flag.
module seq_divider #(
  parameter int BITS = 8
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [BITS:0]   r;
  logic [BITS-1:0] q;
  logic [BITS-1:0] d;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;
  logic            div_by_zero;
  logic            busy;
  logic            done;
  logic            accept;
  logic            zero_div;
  logic            last;
  logic [BITS:0]   t;
  logic [BITS:0]   s;
  logic            c;
  logic [BITS:0]   r_nxt;
  logic [BITS-1:0] q_nxt;
  logic            r_msb_unused;

  function automatic logic [BITS+1:0] trial_sub(input logic [BITS:0] tv,
                                                input logic [BITS-1:0] dv);
    logic [BITS:0] nd;
    nd = ~{1'b0, dv};
    return {1'b0, tv} + {1'b0, nd} + {{(BITS+1){1'b0}}, 1'b1};
  endfunction

  assign accept   = bus.start && (state != RUN);
  assign zero_div = (bus.divisor == '0);
  assign last     = (cnt == CW'(BITS - 1));

  assign t        = {r[BITS-1:0], q[BITS-1]};
  assign {c, s}   = trial_sub(t, d);
  assign r_nxt    = c ? s : t;
  assign q_nxt    = {q[BITS-2:0], c};
  // The partial remainder always stays below d, so its top bit is never read.
  assign r_msb_unused = r[BITS];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_div ? DONE : RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? (zero_div ? DONE : RUN) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (zero_div) begin
        quotient    <= '1;
        remainder   <= bus.dividend;
        div_by_zero <= 1'b1;
      end else begin
        r   <= '0;
        q   <= bus.dividend;
        d   <= bus.divisor;
        cnt <= '0;
      end
    end else if (state == RUN) begin
      r   <= r_nxt;
      q   <= q_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        quotient    <= q_nxt;
        remainder   <= r_nxt[BITS-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: table vectors and corner sequences on an 8-bit instance,
// back-to-back random traffic on a 16-bit instance, scoreboarded per instance.
`timescale 1ns/1ps
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_divider_if #(.BITS(8))  b8();
  seq_divider_if #(.BITS(16)) b16();

  seq_divider #(.BITS(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  seq_divider #(.BITS(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  typedef struct {
    logic [7:0] a, b, q, r;
    logic       z;
  } vec_t;

  typedef struct {
    logic [15:0] a, b, q, r;
    logic        z;
    int          due;
  } exp_t;

  vec_t tbl[12];
  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int   last16 = 0;
  bit   have_last16 = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // 8-bit scoreboard: results, flag and arrival cycle of every done pulse
  always @(negedge clk) begin
    if (b8.done) begin
      if (q8.size() == 0) begin
        check("spurious_done8", b8.done, 0);
      end else begin
        e8 = q8.pop_front();
        check("quot8", b8.quotient, e8.q);
        check("rem8", b8.remainder, e8.r);
        check("dbz8", b8.div_by_zero, e8.z);
        check("lat8", cyc, e8.due);
      end
    end
  end

  // 16-bit scoreboard: reference division, invariant and done spacing
  always @(negedge clk) begin
    if (b16.done) begin
      if (q16.size() == 0) begin
        check("spurious_done16", b16.done, 0);
      end else begin
        e16 = q16.pop_front();
        check("quot16", b16.quotient, e16.q);
        check("rem16", b16.remainder, e16.r);
        check("dbz16", b16.div_by_zero, 0);
        check("lat16", cyc, e16.due);
        check("inv16", longint'(b16.quotient) * longint'(e16.b) + longint'(b16.remainder),
              longint'(e16.a));
        check("rlt16", (b16.remainder < e16.b), 1);
        if (have_last16) check("space16", cyc - last16, 17);
        last16      = cyc;
        have_last16 = 1;
      end
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] qe,
                        input logic [7:0] re, input logic z);
    exp_t e;
    @(negedge clk);
    b8.start    = 1'b1;
    b8.dividend = a;
    b8.divisor  = b;
    e = '{16'(a), 16'(b), 16'(qe), 16'(re), z, cyc + 1 + ((b == 8'd0) ? 0 : 8)};
    q8.push_back(e);
    @(negedge clk);
    b8.start = 1'b0;
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!b8.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!b8.done) check("timeout8", b8.done, 1);
    @(negedge clk);
  endtask

  task automatic check_zero8(input string nm);
    check({nm, "_busy"}, b8.busy, 0);
    check({nm, "_done"}, b8.done, 0);
    check({nm, "_quot"}, b8.quotient, 0);
    check({nm, "_rem"}, b8.remainder, 0);
    check({nm, "_dbz"}, b8.div_by_zero, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int pushed;
    bit changed;
    int guard;

    tbl[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
    tbl[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    tbl[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    tbl[3]  = '{8'd200, 8'd200, 8'd1,   8'd0,   1'b0};
    tbl[4]  = '{8'd42,  8'd0,   8'd255, 8'd42,  1'b1};
    tbl[5]  = '{8'd42,  8'd6,   8'd7,   8'd0,   1'b0};
    tbl[6]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    tbl[7]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    tbl[8]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
    tbl[9]  = '{8'd1,   8'd0,   8'd255, 8'd1,   1'b1};
    tbl[10] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
    tbl[11] = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0};

    b8.start = 1'b0;  b8.dividend = '0;  b8.divisor = '0;
    b16.start = 1'b0; b16.dividend = '0; b16.divisor = '0;

    repeat (3) @(negedge clk);
    check_zero8("reset8");
    check("reset16_busy", b16.busy, 0);
    check("reset16_done", b16.done, 0);
    check("reset16_quot", b16.quotient, 0);
    check("reset16_rem", b16.remainder, 0);
    rst = 1'b0;

    // 100/7: busy across cycles 1..8, done alone in cycle 9
    issue8(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      check("run_busy", b8.busy, 1);
      check("run_done", b8.done, 0);
    end
    @(negedge clk);
    check("fin_done", b8.done, 1);
    check("fin_busy", b8.busy, 0);
    @(negedge clk);
    check("idle_done", b8.done, 0);

    // divide by zero answers in cycle 1 without busy, then a normal divide clears the flag
    issue8(8'd42, 8'd0, 8'd255, 8'd42, 1'b1);
    check("dbz_done", b8.done, 1);
    check("dbz_busy", b8.busy, 0);
    issue8(8'd42, 8'd6, 8'd7, 8'd0, 1'b0);
    wait_done8();

    for (int i = 0; i < 12; i++) begin
      issue8(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z);
      wait_done8();
    end

    // a start pulse in mid-run is ignored
    issue8(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    repeat (3) @(negedge clk);
    b8.start = 1'b1; b8.dividend = 8'd9; b8.divisor = 8'd3;
    @(negedge clk);
    b8.start = 1'b0;
    wait_done8();
    repeat (12) @(negedge clk);
    check("sb8_empty", q8.size(), 0);

    // reset in cycle 5 aborts the divide with no done
    issue8(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero8("abort");
    q8.delete();
    repeat (14) @(negedge clk);
    check("abort_busy", b8.busy, 0);

    // reset wins over a start in the same cycle
    b8.start = 1'b1; b8.dividend = 8'd100; b8.divisor = 8'd7; rst = 1'b1;
    @(negedge clk);
    b8.start = 1'b0; rst = 1'b0;
    check_zero8("rst_start");
    repeat (12) @(negedge clk);
    check("rst_start_busy", b8.busy, 0);

    // 16-bit back-to-back traffic with start held high
    @(negedge clk);
    b16.dividend = 16'($urandom);
    b16.divisor  = 16'($urandom_range(1, 65535));
    b16.start    = 1'b1;
    pushed  = 0;
    changed = 1;
    guard   = 0;
    while (pushed < 20 && guard < 1000) begin
      if (!b16.busy && changed) begin
        q16.push_back('{b16.dividend, b16.divisor, b16.dividend / b16.divisor,
                        b16.dividend % b16.divisor, 1'b0, cyc + 17});
        pushed++;
        changed = 0;
      end
      @(negedge clk);
      guard++;
      if (b16.busy && !changed) begin
        b16.dividend = 16'($urandom);
        b16.divisor  = (pushed % 5 == 4) ? 16'($urandom_range(1, 15))
                                         : 16'($urandom_range(1, 65535));
        changed = 1;
      end
    end
    b16.start = 1'b0;
    check("burst_pushed", pushed, 20);
    guard = 0;
    while (q16.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain16", q16.size(), 0);
    repeat (3) @(negedge clk);
    check("sb8_final", q8.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative unsigned restoring divider for the ALU datapath: it produces quotient and remainder of two `BITS`-wide operands, retiring one quotient bit per clock. Each trial subtraction is performed as addition of the one's complement with carry-in 1. The carry-out acts as the no-borrow flag, so the block is the subtractive counterpart of the parametric carry-lookahead adder. It sits beside the adder in the ALU and handles the divide opcodes through a start/done handshake.

## Interface
- `BITS`, default 8, operand/result width; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only while `busy`=0.
- `dividend`  in  BITS  unsigned numerator, sampled with accepted `start`.
- `divisor`  in  BITS  unsigned denominator, sampled with accepted `start`.
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse: results valid.
- `quotient`  out  BITS  registered result, held until next `done`.
- `remainder`  out  BITS  registered result, held until next `done`.
- `div_by_zero`  out  1  set with `done` when divisor was 0; held with results.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1.
  - DONE: `done`=1, `busy`=0, lasts exactly one cycle.
- Internal registers:
  - `r`: partial remainder, BITS+1 bits.
  - `q`: dividend/quotient shift register, BITS bits.
  - `d`: latched divisor.
  - `cnt`: width `$clog2(BITS+1)`.
- Accept: `start`=1 while in IDLE or DONE.
  - Divisor ≠ 0: load r=0, q=dividend, d=divisor, cnt=0, go to RUN.
  - Divisor = 0: go to DONE directly; quotient = all ones, remainder = dividend, `div_by_zero`=1.
- RUN iteration (one per cycle):
  - Form t = {r[BITS-1:0], q[BITS-1]}.
  - Compute s = t + ~{1'b0,d} + 1 at BITS+1 bits, with carry-out c.
  - If c=1 (t ≥ d): r=s, and shift q left inserting 1.
  - Else: r=t, and shift q left inserting 0.
  - cnt++.
- Exit: after the iteration at cnt = BITS-1, go to DONE.
  - Load `quotient` = final q, `remainder` = final r[BITS-1:0], `div_by_zero` = 0.
- DONE → IDLE next cycle unless a new `start` is accepted (back-to-back allowed).
- `start` while `busy`=1 is ignored; operand changes during RUN have no effect.
- Invariant: dividend = quotient·divisor + remainder, and remainder < divisor, whenever divisor ≠ 0.

## Timing
- Reset:
  - State IDLE.
  - `busy`, `done`, `div_by_zero` = 0.
  - `quotient`, `remainder` = 0.
  - Internal r, q, d, cnt = 0.
- `rst` overrides everything, including `start` in the same cycle and a RUN in progress.
  - The aborted operation produces no `done`.
  - Outputs return to reset values the cycle after `rst`.
- Normal latency, with `start` accepted in cycle 0:
  - `busy`=1 in cycles 1..BITS.
  - `done`=1 in cycle BITS+1.
  - Results change at the same edge that raises `done`.
- Divide-by-zero latency: `done`=1 in cycle 1; `busy` never asserted.
- Back-to-back: `start` in the DONE cycle is accepted, so `busy`=1 in the following cycle.
  - Throughput is one operation per BITS+1 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- BITS=8, 100/7, start in cycle 0 → `busy` in cycles 1–8; `done` in cycle 9 with quotient=14, remainder=2, `div_by_zero`=0.
- BITS=8, 255/1 → quotient=255, remainder=0. 5/9 → quotient=0, remainder=5. 200/200 → quotient=1, remainder=0.
- BITS=8, 42/0 → `done` in cycle 1 with quotient=255, remainder=42, `div_by_zero`=1. A following 42/6 → quotient=7 with `div_by_zero`=0.
- Start 100/7, then pulse `start` with 9/3 in cycle 4 → the second start is ignored; `done` in cycle 9 gives 14 rem 2, and exactly one `done` pulse occurs.
- Start 100/7, assert `rst` in cycle 5 → from cycle 6 all outputs are 0, and no `done` occurs for that operation.
- Random BITS=16 operands with `start` held high continuously → every `done` arrives at a spacing of 17 cycles and satisfies the quotient/remainder invariant.
